// File: rtl/instr_mem_pipe_if.sv
// instr_mem_pipe_if: fetch bus between a core front-end and the instruction memory.
//   master (fetch unit) drives req_valid, req_addr, rsp_ready, flush.
//   slave  (memory)     drives req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err.
//   req_*     : valid/ready request channel carrying a byte address (PC)
//   rsp_*     : valid/ready response channel with instruction, its address and error flag
//   flush     : drops every in-flight response
interface instr_mem_pipe_if #(
    parameter int unsigned DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [31:0]       req_addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_instr;
    logic [31:0]       rsp_addr;
    logic              rsp_err;
    logic              flush;

    modport master (
        output req_valid, req_addr, rsp_ready, flush,
        input  req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready, flush,
        output req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err
    );
endinterface

// File: rtl/instr_mem_pipe.sv
// instr_mem_pipe: synchronous instruction memory behind a valid/ready fetch interface.
//   1- or 2-cycle registered read (RD_LATENCY), backpressure, flush and address-error flagging.
//   Out-of-range addresses return DEFAULT_WORD with rsp_err; misaligned addresses return the
//   word at the index with rsp_err.
// Ports:
//   clk     : rising-edge clock
//   reset   : synchronous, active-high
//   bus     : instr_mem_pipe_if slave (req_*, rsp_*, flush)
//   ld_we, ld_addr, ld_data : load port, present only with IMEM_LOAD_PORT_EN defined
// Configuration:
//   IMEM_LOAD_PORT_EN : adds the ld_* write port; fetch is refused in a load cycle.
module instr_mem_pipe #(
    parameter int unsigned       ADDR_BITS    = 7,
    parameter int unsigned       DATA_W       = 32,
    parameter int unsigned       RD_LATENCY   = 1,
    parameter logic [DATA_W-1:0] DEFAULT_WORD = 32'h8000_0000,
    parameter string             INIT_FILE    = ""
) (
    input  logic                 clk,
    input  logic                 reset,
`ifdef IMEM_LOAD_PORT_EN
    input  logic                 ld_we,
    input  logic [ADDR_BITS-1:0] ld_addr,
    input  logic [DATA_W-1:0]    ld_data,
`endif
    instr_mem_pipe_if.slave      bus
);

    localparam int unsigned Depth = 2 ** ADDR_BITS;

    logic [DATA_W-1:0] mem_q [Depth];

    logic                 advance;
    logic                 accept;
    logic [ADDR_BITS-1:0] idx;
    logic                 oor;
    logic                 mis;

    assign advance = !bus.rsp_valid || bus.rsp_ready;
`ifdef IMEM_LOAD_PORT_EN
    assign bus.req_ready = advance && !bus.flush && !ld_we;
`else
    assign bus.req_ready = advance && !bus.flush;
`endif
    assign accept = bus.req_valid && bus.req_ready;
    assign idx    = bus.req_addr[ADDR_BITS+1:2];
    assign oor    = |bus.req_addr[31:ADDR_BITS+2];
    assign mis    = |bus.req_addr[1:0];

    // Array port: read only on advance so a stalled response keeps its data.
    logic [DATA_W-1:0] rd_q;

    always_ff @(posedge clk) begin
        if (advance) rd_q <= mem_q[idx];
`ifdef IMEM_LOAD_PORT_EN
        if (ld_we) mem_q[ld_addr] <= ld_data;
`endif
    end

    // Stage 1: request bookkeeping alongside the array read.
    logic        s1_valid_q, s1_valid_d;
    logic [31:0] s1_addr_q;
    logic        s1_err_q;
    logic        s1_dflt_q;    // substitute DEFAULT_WORD for the array output

    always_comb begin
        s1_valid_d = s1_valid_q;
        if (advance)  s1_valid_d = accept;
        if (bus.flush) s1_valid_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_addr_q  <= '0;
            s1_err_q   <= 1'b0;
            s1_dflt_q  <= 1'b1;     // makes rsp_instr read DEFAULT_WORD out of reset
        end else begin
            s1_valid_q <= s1_valid_d;
            if (advance) begin
                s1_addr_q <= bus.req_addr;
                s1_err_q  <= oor | mis;
                s1_dflt_q <= oor;
            end
        end
    end

    logic [DATA_W-1:0] s1_data;
    assign s1_data = s1_dflt_q ? DEFAULT_WORD : rd_q;

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic              s2_valid_q, s2_valid_d;
            logic [DATA_W-1:0] s2_data_q;
            logic [31:0]       s2_addr_q;
            logic              s2_err_q;

            always_comb begin
                s2_valid_d = s2_valid_q;
                if (advance)  s2_valid_d = s1_valid_q;
                if (bus.flush) s2_valid_d = 1'b0;
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    s2_valid_q <= 1'b0;
                    s2_data_q  <= DEFAULT_WORD;
                    s2_addr_q  <= '0;
                    s2_err_q   <= 1'b0;
                end else begin
                    s2_valid_q <= s2_valid_d;
                    if (advance) begin
                        s2_data_q <= s1_data;
                        s2_addr_q <= s1_addr_q;
                        s2_err_q  <= s1_err_q;
                    end
                end
            end

            assign bus.rsp_valid = s2_valid_q;
            assign bus.rsp_instr = s2_data_q;
            assign bus.rsp_addr  = s2_addr_q;
            assign bus.rsp_err   = s2_err_q;
        end else if (RD_LATENCY == 1) begin : g_lat1
            assign bus.rsp_valid = s1_valid_q;
            assign bus.rsp_instr = s1_data;
            assign bus.rsp_addr  = s1_addr_q;
            assign bus.rsp_err   = s1_err_q;
        end else begin : g_bad_latency
            $error("instr_mem_pipe: RD_LATENCY must be 1 or 2");
            assign bus.rsp_valid = 1'b0;
            assign bus.rsp_instr = DEFAULT_WORD;
            assign bus.rsp_addr  = '0;
            assign bus.rsp_err   = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_instr_mem_pipe.sv
module tb_instr_mem_pipe;
    localparam logic [31:0] DEF = 32'h8000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        err;
    } rsp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        rsp_ready;
    logic        flush;
    logic        req_valid [2];
    logic [31:0] req_addr  [2];
    logic        req_ready_o [2];
    logic        rsp_valid_o [2];
    logic [31:0] rsp_instr_o [2];
    logic [31:0] rsp_addr_o  [2];
    logic        rsp_err_o   [2];

    logic [31:0] model_mem [128];
    int checks = 0;
    int errors = 0;

`ifdef IMEM_LOAD_PORT_EN
    logic        ld_we;
    logic [6:0]  ld_addr;
    logic [31:0] ld_data;
`endif

    instr_mem_pipe_if #(.DATA_W(32)) bus1 ();
    instr_mem_pipe_if #(.DATA_W(32)) bus2 ();

    assign bus1.req_valid = req_valid[0];
    assign bus1.req_addr  = req_addr[0];
    assign bus1.rsp_ready = rsp_ready;
    assign bus1.flush     = flush;
    assign bus2.req_valid = req_valid[1];
    assign bus2.req_addr  = req_addr[1];
    assign bus2.rsp_ready = rsp_ready;
    assign bus2.flush     = flush;

    assign req_ready_o[0] = bus1.req_ready;
    assign rsp_valid_o[0] = bus1.rsp_valid;
    assign rsp_instr_o[0] = bus1.rsp_instr;
    assign rsp_addr_o[0]  = bus1.rsp_addr;
    assign rsp_err_o[0]   = bus1.rsp_err;
    assign req_ready_o[1] = bus2.req_ready;
    assign rsp_valid_o[1] = bus2.rsp_valid;
    assign rsp_instr_o[1] = bus2.rsp_instr;
    assign rsp_addr_o[1]  = bus2.rsp_addr;
    assign rsp_err_o[1]   = bus2.rsp_err;

    instr_mem_pipe #(
        .ADDR_BITS(7), .DATA_W(32), .RD_LATENCY(1), .DEFAULT_WORD(DEF), .INIT_FILE("")
    ) u_dut1 (
        .clk(clk),
        .reset(reset),
`ifdef IMEM_LOAD_PORT_EN
        .ld_we(ld_we),
        .ld_addr(ld_addr),
        .ld_data(ld_data),
`endif
        .bus(bus1)
    );

    instr_mem_pipe #(
        .ADDR_BITS(7), .DATA_W(32), .RD_LATENCY(2), .DEFAULT_WORD(DEF), .INIT_FILE("")
    ) u_dut2 (
        .clk(clk),
        .reset(reset),
`ifdef IMEM_LOAD_PORT_EN
        .ld_we(ld_we),
        .ld_addr(ld_addr),
        .ld_data(ld_data),
`endif
        .bus(bus2)
    );

    // Reference: what a fetch of byte address a must return.
    function automatic rsp_t expect_of(input logic [31:0] a);
        rsp_t r;
        r.addr = a;
        if (a >= 32'd512) begin
            r.instr = DEF;
            r.err   = 1'b1;
        end else begin
            r.instr = model_mem[int'(a / 4)];
            r.err   = (a % 4) != 0;
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_addr();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r < 6) return 32'($urandom_range(0, 127)) << 2;
        if (r < 8) return (32'($urandom_range(0, 127)) << 2) | 32'($urandom_range(1, 3));
        return $urandom() | 32'h0000_0200;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b0;
        flush = 1'b0;
        rsp_ready = 1'b1;
    endtask

    task automatic write_word(input int i, input logic [31:0] w);
        model_mem[i] = w;
`ifdef IMEM_LOAD_PORT_EN
        ld_we = 1'b1;
        ld_addr = 7'(i);
        ld_data = w;
        step();
        ld_we = 1'b0;
`else
        u_dut1.mem_q[i] = w;
        u_dut2.mem_q[i] = w;
`endif
    endtask

    task automatic test_reset();
        repeat (3) step();
        reset = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (rsp_valid_o[k] !== 1'b0) begin
                errors++; $display("FAIL reset_valid dut%0d: got %b expected 0", k, rsp_valid_o[k]);
            end
            checks++;
            if (rsp_instr_o[k] !== DEF) begin
                errors++; $display("FAIL reset_instr dut%0d: got %h expected %h", k, rsp_instr_o[k], DEF);
            end
            checks++;
            if (rsp_addr_o[k] !== 32'h0 || rsp_err_o[k] !== 1'b0) begin
                errors++; $display("FAIL reset_addr_err dut%0d: got %h/%b expected 0/0", k,
                                   rsp_addr_o[k], rsp_err_o[k]);
            end
            checks++;
            if (req_ready_o[k] !== 1'b1) begin
                errors++; $display("FAIL reset_ready dut%0d: got %b expected 1", k, req_ready_o[k]);
            end
        end
        step();
    endtask

    // Accept at cycle 0; lat1 answers at cycle 1, lat2 at cycle 2.
    task automatic test_single_fetch();
        write_word(3, 32'h2008_0014);
        idle();
        req_valid[0] = 1'b1; req_addr[0] = 32'h0C;
        req_valid[1] = 1'b1; req_addr[1] = 32'h0C;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (req_ready_o[k] !== 1'b1) begin
                errors++; $display("FAIL single_ready dut%0d: got %b expected 1", k, req_ready_o[k]);
            end
        end
        step();
        for (int c = 1; c <= 3; c++) begin
            req_valid[0] = 1'b0;
            req_valid[1] = 1'b0;
            #1;
            for (int k = 0; k < 2; k++) begin
                logic ev;
                ev = (c == k + 1);
                checks++;
                if (rsp_valid_o[k] !== ev) begin
                    errors++; $display("FAIL single_valid dut%0d c%0d: got %b expected %b", k, c,
                                       rsp_valid_o[k], ev);
                end
                if (ev) begin
                    checks++;
                    if (rsp_instr_o[k] !== 32'h2008_0014 || rsp_addr_o[k] !== 32'h0C ||
                        rsp_err_o[k] !== 1'b0) begin
                        errors++; $display("FAIL single_rsp dut%0d: got %h/%h/%b expected 20080014/0000000c/0",
                                           k, rsp_instr_o[k], rsp_addr_o[k], rsp_err_o[k]);
                    end
                end
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 7; c++) begin
            idle();
            for (int k = 0; k < 2; k++) begin
                req_valid[k] = (c < 4);
                req_addr[k]  = 32'(c * 4);
            end
            #1;
            for (int k = 0; k < 2; k++) begin
                int j;
                logic ev;
                rsp_t e;
                rsp_t obs;
                j = c - (k + 1);
                ev = (j >= 0 && j < 4);
                if (c < 4) begin
                    checks++;
                    if (req_ready_o[k] !== 1'b1) begin
                        errors++; $display("FAIL b2b_ready dut%0d c%0d: got %b expected 1", k, c,
                                           req_ready_o[k]);
                    end
                end
                checks++;
                if (rsp_valid_o[k] !== ev) begin
                    errors++; $display("FAIL b2b_valid dut%0d c%0d: got %b expected %b", k, c,
                                       rsp_valid_o[k], ev);
                end
                if (ev) begin
                    e = expect_of(32'(j * 4));
                    obs = '{instr: rsp_instr_o[k], addr: rsp_addr_o[k], err: rsp_err_o[k]};
                    checks++;
                    if (obs !== e) begin
                        errors++; $display("FAIL b2b_rsp dut%0d c%0d: got %h expected %h", k, c, obs, e);
                    end
                end
            end
            step();
        end
    endtask

    // Four requests from 0x20 with the consumer stalled in cycles 3..5.
    task automatic test_stall();
        int iss [2];
        int con [2];
        logic acc [2];
        iss = '{0, 0};
        con = '{0, 0};
        acc = '{1'b0, 1'b0};
        for (int c = 0; c < 20; c++) begin
            idle();
            rsp_ready = !(c >= 3 && c < 6);
            for (int k = 0; k < 2; k++) begin
                if (acc[k]) iss[k]++;
                req_valid[k] = (iss[k] < 4);
                req_addr[k]  = 32'h20 + 32'(iss[k] * 4);
            end
            #1;
            for (int k = 0; k < 2; k++) begin
                rsp_t e;
                rsp_t obs;
                acc[k] = req_valid[k] && req_ready_o[k];
                if (rsp_valid_o[k] === 1'b1) begin
                    if (con[k] >= iss[k]) begin
                        checks++; errors++;
                        $display("FAIL stall_extra dut%0d c%0d: got rsp with %0d issued expected none",
                                 k, c, iss[k]);
                    end else begin
                        e = expect_of(32'h20 + 32'(con[k] * 4));
                        obs = '{instr: rsp_instr_o[k], addr: rsp_addr_o[k], err: rsp_err_o[k]};
                        checks++;
                        if (obs !== e) begin
                            errors++; $display("FAIL stall_rsp dut%0d c%0d: got %h expected %h", k, c,
                                               obs, e);
                        end
                        if (rsp_ready) con[k]++;
                        else begin
                            checks++;
                            if (req_ready_o[k] !== 1'b0) begin
                                errors++; $display("FAIL stall_ready dut%0d c%0d: got %b expected 0",
                                                   k, c, req_ready_o[k]);
                            end
                        end
                    end
                end
            end
            step();
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (con[k] != 4 || iss[k] + int'(acc[k]) != 4) begin
                errors++; $display("FAIL stall_count dut%0d: got %0d consumed expected 4", k, con[k]);
            end
        end
        idle();
    endtask

    task automatic test_addr_err();
        logic [31:0] al [2];
        al[0] = 32'h0000_0200;
        al[1] = 32'h0000_0006;
        for (int c = 0; c < 4; c++) begin
            idle();
            for (int k = 0; k < 2; k++) begin
                req_valid[k] = (c < 2);
                req_addr[k]  = al[c % 2];
            end
            #1;
            for (int k = 0; k < 2; k++) begin
                int j;
                logic [31:0] ei;
                j = c - (k + 1);
                if (j >= 0 && j < 2) begin
                    ei = (j == 0) ? DEF : model_mem[1];
                    checks++;
                    if (rsp_valid_o[k] !== 1'b1 || rsp_instr_o[k] !== ei || rsp_err_o[k] !== 1'b1 ||
                        rsp_addr_o[k] !== al[j]) begin
                        errors++; $display("FAIL addr_err dut%0d a=%h: got %b/%h/%b expected 1/%h/1",
                                           k, al[j], rsp_valid_o[k], rsp_instr_o[k], rsp_err_o[k], ei);
                    end
                end
            end
            step();
        end
    endtask

    task automatic test_flush();
        for (int c = 0; c < 9; c++) begin
            idle();
            for (int k = 0; k < 2; k++) begin
                req_valid[k] = (c <= 2);
                req_addr[k]  = 32'(c * 4);
            end
            if (c == 2) begin
                flush = 1'b1;
                rsp_ready = 1'b0;
            end
            #1;
            for (int k = 0; k < 2; k++) begin
                if (c == 2) begin
                    checks++;
                    if (req_ready_o[k] !== 1'b0) begin
                        errors++; $display("FAIL flush_ready dut%0d: got %b expected 0", k, req_ready_o[k]);
                    end
                    checks++;
                    if (rsp_valid_o[k] !== 1'b1) begin
                        errors++; $display("FAIL flush_pre dut%0d: got %b expected 1", k, rsp_valid_o[k]);
                    end
                end else if (c > 2) begin
                    checks++;
                    if (rsp_valid_o[k] !== 1'b0) begin
                        errors++; $display("FAIL flush_post dut%0d c%0d: got %b expected 0", k, c,
                                           rsp_valid_o[k]);
                    end
                end
            end
            step();
        end
    endtask

    task automatic test_reset_midfetch();
        for (int c = 0; c < 3; c++) begin
            idle();
            rsp_ready = 1'b0;
            req_valid[0] = (c == 0); req_addr[0] = 32'h10;
            req_valid[1] = (c == 0); req_addr[1] = 32'h10;
            #1;
            step();
        end
        idle();
        rsp_ready = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (rsp_valid_o[k] !== 1'b1) begin
                errors++; $display("FAIL midreset_pre dut%0d: got %b expected 1", k, rsp_valid_o[k]);
            end
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (rsp_valid_o[k] !== 1'b0 || rsp_instr_o[k] !== DEF || req_ready_o[k] !== 1'b1) begin
                errors++; $display("FAIL midreset dut%0d: got %b/%h/%b expected 0/%h/1", k,
                                   rsp_valid_o[k], rsp_instr_o[k], req_ready_o[k], DEF);
            end
        end
        idle();
        step();
    endtask

`ifdef IMEM_LOAD_PORT_EN
    task automatic test_load();
        idle();
        ld_we = 1'b1; ld_addr = 7'd5; ld_data = 32'hDEAD_BEEF;
        req_valid[0] = 1'b1; req_addr[0] = 32'h10;
        req_valid[1] = 1'b1; req_addr[1] = 32'h10;
        model_mem[5] = 32'hDEAD_BEEF;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (req_ready_o[k] !== 1'b0) begin
                errors++; $display("FAIL load_ready dut%0d: got %b expected 0", k, req_ready_o[k]);
            end
        end
        step();
        ld_we = 1'b0;
        req_addr[0] = 32'h14;
        req_addr[1] = 32'h14;
        step();
        for (int c = 1; c <= 2; c++) begin
            idle();
            #1;
            checks++;
            if (rsp_valid_o[c-1] !== 1'b1 || rsp_instr_o[c-1] !== 32'hDEAD_BEEF) begin
                errors++; $display("FAIL load_fetch dut%0d: got %b/%h expected 1/deadbeef", c - 1,
                                   rsp_valid_o[c-1], rsp_instr_o[c-1]);
            end
            step();
        end
    endtask
`endif

    // Random traffic, backpressure and flushes against an in-order expected-response queue.
    task automatic test_random();
        rsp_t sbq [2][$];
        logic acc [2];
        acc = '{1'b0, 1'b0};
        for (int c = 0; c < 310; c++) begin
            logic gen;
            gen = (c < 300);
            for (int k = 0; k < 2; k++) begin
                if (acc[k] || !gen) req_valid[k] = 1'b0;
                if (gen && !req_valid[k] && $urandom_range(0, 3) != 0) begin
                    req_valid[k] = 1'b1;
                    req_addr[k]  = rand_addr();
                end
            end
            rsp_ready = gen ? ($urandom_range(0, 3) != 0) : 1'b1;
            flush     = gen ? ($urandom_range(0, 19) == 0) : 1'b0;
            #1;
            for (int k = 0; k < 2; k++) begin
                logic exp_rdy;
                rsp_t obs;
                acc[k] = 1'b0;
                exp_rdy = (!rsp_valid_o[k] || rsp_ready) && !flush;
                checks++;
                if (req_ready_o[k] !== exp_rdy) begin
                    errors++; $display("FAIL rand_ready dut%0d c%0d: got %b expected %b", k, c,
                                       req_ready_o[k], exp_rdy);
                end
                if (rsp_valid_o[k] === 1'b1) begin
                    checks++;
                    if (sbq[k].size() == 0) begin
                        errors++; $display("FAIL rand_extra dut%0d c%0d: got rsp %h expected none", k, c,
                                           rsp_addr_o[k]);
                    end else begin
                        obs = '{instr: rsp_instr_o[k], addr: rsp_addr_o[k], err: rsp_err_o[k]};
                        if (obs !== sbq[k][0]) begin
                            errors++; $display("FAIL rand_rsp dut%0d c%0d: got %h expected %h", k, c,
                                               obs, sbq[k][0]);
                        end
                        if (rsp_ready) void'(sbq[k].pop_front());
                    end
                end
                if (flush) sbq[k].delete();
                else if (req_valid[k] && exp_rdy) begin
                    sbq[k].push_back(expect_of(req_addr[k]));
                    acc[k] = 1'b1;
                end
            end
            step();
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (sbq[k].size() != 0) begin
                errors++; $display("FAIL rand_lost dut%0d: got %0d outstanding expected 0", k,
                                   sbq[k].size());
            end
        end
        idle();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        req_addr[0] = '0;
        req_addr[1] = '0;
`ifdef IMEM_LOAD_PORT_EN
        ld_we = 1'b0;
        ld_addr = '0;
        ld_data = '0;
`endif
        for (int i = 0; i < 128; i++) write_word(i, $urandom());
        test_reset();
        test_single_fetch();
        test_back_to_back();
        test_stall();
        test_addr_err();
        test_flush();
        test_reset_midfetch();
`ifdef IMEM_LOAD_PORT_EN
        test_load();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish before 2000000");
        $fatal(1);
    end

endmodule
